// File: rtl/constants.sv
// Shared data-path constants: word width, store encodings, DRAM responder states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package constants;

    localparam int data_size = 32;

    // Store width encodings shared with the core's store path.
    typedef enum logic [1:0] {
        sb_conf = 2'd0,
        sh_conf = 2'd1,
        sw_conf = 2'd2
    } store_conf;

    // DRAM responder FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RMW_RD    = 2'd2,
        RMW_WR    = 2'd3
    } dram_state_t;

    // Default read latency in cycles (legal 1..4).
    localparam int dram_read_lat = 2;

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous word array: write on the edge, registered read.
// Latency: read data appears on rdata one cycle after re is sampled.
// Backpressure: none; one access per cycle, rdata holds until the next read.
module dram_array #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_d;

    // Read register only updates on a read so the last word stays visible.
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = mem_q[addr];
        end
    end

    // Read register is reset so the data output starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Storage itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = rd_q;

endmodule

// File: rtl/dram_memory.sv
// Memory-side responder: 2**ADDR_W x 32 array behind a DRAM-controller request port.
// Latency: reads return READ_LAT cycles after accept; sw one cycle; sb/sh three cycles with DRAM_RMW_EN.
// Backpressure: dram_ready low while a read or RMW is in flight; requests are ignored while low.
// Build option: define DRAM_RMW_EN to merge sb/sh into the old word; otherwise all writes store dram_datain as-is.
module dram_memory
    import constants::*;
#(
    parameter int ADDR_W   = 9,
    parameter int READ_LAT = dram_read_lat
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dram_re,
    input  logic                 dram_we,
    input  logic [ADDR_W-1:0]    dram_address,
    input  logic [data_size-1:0] dram_datain,
    input  store_conf            store_type,
    output logic                 dram_ready,
    output logic                 dram_rvalid,
    output logic [data_size-1:0] dmem_word
);

    dram_state_t          state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 rvalid_q, rvalid_d;
    logic                 ready_q, ready_d;
    logic [data_size-1:0] hold_q, hold_d;

    logic                 arr_we;
    logic                 arr_re;
    logic [ADDR_W-1:0]    arr_addr;
    logic [data_size-1:0] arr_wdata;
    logic [data_size-1:0] arr_rdata;

`ifdef DRAM_RMW_EN
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [data_size-1:0] data_q, data_d;
    store_conf            type_q, type_d;

    // Sub-word data is right-aligned; only the low byte/half replaces the old word.
    function automatic logic [data_size-1:0] merge_word(
        input logic [data_size-1:0] old_w,
        input logic [data_size-1:0] new_w,
        input store_conf            st
    );
        logic [data_size-1:0] res;
        case (st)
            sb_conf: res = {old_w[data_size-1:8],  new_w[7:0]};
            sh_conf: res = {old_w[data_size-1:16], new_w[15:0]};
            default: res = new_w;
        endcase
        return res;
    endfunction
`else
    // Store width is irrelevant when every write stores the full input word.
    logic unused_store_type;
    assign unused_store_type = ^store_type;
`endif

    // Next-state, array control and output-register computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        hold_d    = rvalid_q ? arr_rdata : hold_q;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = dram_address;
        arr_wdata = dram_datain;
`ifdef DRAM_RMW_EN
        addr_d    = addr_q;
        data_d    = data_q;
        type_d    = type_q;
`endif
        case (state_q)
            IDLE: begin
                // Write wins when both request strobes are high.
                if (ready_q && dram_we) begin
`ifdef DRAM_RMW_EN
                    if (store_type != sw_conf) begin
                        addr_d  = dram_address;
                        data_d  = dram_datain;
                        type_d  = store_type;
                        state_d = RMW_RD;
                    end else begin
                        arr_we = 1'b1;
                    end
`else
                    arr_we = 1'b1;
`endif
                end else if (ready_q && dram_re) begin
                    // The array is read on the accept edge; the wait only delays the response.
                    arr_re = 1'b1;
                    if (READ_LAT == 1) begin
                        rvalid_d = 1'b1;
                    end else begin
                        state_d = READ_WAIT;
                        cnt_d   = 2'(READ_LAT - 1);
                    end
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                end
            end
`ifdef DRAM_RMW_EN
            RMW_RD: begin
                arr_addr = addr_q;
                arr_re   = 1'b1;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                arr_addr  = addr_q;
                arr_we    = 1'b1;
                arr_wdata = merge_word(arr_rdata, data_q, type_q);
                state_d   = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // Reset drops any pending read or RMW; ready comes back on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            hold_q   <= '0;
`ifdef DRAM_RMW_EN
            addr_q   <= '0;
            data_q   <= '0;
            type_q   <= sw_conf;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
            hold_q   <= hold_d;
`ifdef DRAM_RMW_EN
            addr_q   <= addr_d;
            data_q   <= data_d;
            type_q   <= type_d;
`endif
        end
    end

    dram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (data_size)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // The array read register may be reused by an RMW, so the returned word is held separately.
    assign dmem_word   = rvalid_q ? arr_rdata : hold_q;
    assign dram_ready  = ready_q;
    assign dram_rvalid = rvalid_q;

endmodule
